mem_skew_feeder: RTL and testbench
==================================

// Module: mem_skew_feeder
// PURPOSE
//  Read sequencer directly downstream of the 4x4 operand memory; turns one stored tile into a skewed wavefront for the systolic array.
//  On start, walks 2*DIM-1 diagonal steps, driving the memory's per-column read enables and row selects.
//  Registers the memory's asynchronous read data into lane outputs, so lane i trails lane i-1 by one cycle.
//  A downstream hold stalls the walk without losing data.
// PARAMETERS
//  DATA_WIDTH  8  bits per memory element / feed lane
//  DIM         4  array dimension (rows = columns = lanes); IDXW = $clog2(DIM) localparam
// PORTS
//  clk         in   1              clock, all state on rising edge
//  rst         in   1              synchronous reset, active-high
//  start       in   1              begin one tile walk; sampled only in IDLE
//  hold        in   1              downstream stall; effective in RUN/DRAIN only
//  busy        out  1              high in RUN and DRAIN
//  done        out  1              one-cycle pulse on last DRAIN cycle
//  rd_en       out  DIM            to memory read_enable; bit i enables column i
//  rd_elem     out  DIM*IDXW       to memory read_elem; [IDXW*i +: IDXW] = row for column i
//  mem_data    in   DIM*DATA_WIDTH from memory data_out; [DATA_WIDTH*i +: DATA_WIDTH] = column i
//  feed_data   out  DIM*DATA_WIDTH registered lane data to array, same packing
//  feed_valid  out  DIM            registered per-lane valid
// BEHAVIOUR
//  Reset: state=IDLE, step=0; busy, done, rd_en, rd_elem, feed_data, feed_valid all 0. Reset mid-walk aborts, no done.
//  States: IDLE -> RUN (start=1) ; RUN -> DRAIN when step==2*DIM-2 and hold=0 ; DRAIN -> IDLE when hold=0.
//  step: IDXW+1-bit counter, 0..2*DIM-2; cleared on IDLE->RUN; +1 per RUN cycle with hold=0; no wrap.
//  rd_en/rd_elem: combinational from state and step; zero outside RUN.
//   In RUN: rd_en[i] = (step >= i) && (step-i < DIM); rd_elem lane i = (step-i) truncated to IDXW bits, 0 when disabled.
//  Memory read is async: mem_data is sampled the same cycle rd_* are driven.
//  Feed regs: each RUN/DRAIN cycle with hold=0: feed_data <= mem_data masked by rd_en (0 when rd_en[i]=0), feed_valid <= rd_en.
//   IDLE: feed_valid <= 0, feed_data <= 0.
//  Latency: start high at cycle N -> RUN steps 0..2*DIM-2 in cycles N+1..N+2*DIM-1.
//   Step t appears on feed_* at cycle N+2+t. DRAIN at N+2*DIM with done=1; IDLE at N+2*DIM+1.
//  hold=1 in RUN/DRAIN: step, state, feed_data, feed_valid frozen; rd_* stay at current step; done suppressed until hold drops.
//  start while busy: ignored (no queueing). start and hold both high in IDLE: start accepted.
//  Back-to-back: start high in the cycle after done is accepted normally (one idle cycle between tiles).
// STRUCTURE
//  Shared package tpu_pkg: DATA_WIDTH, DIM, IDXW constants; state enum {IDLE, RUN, DRAIN}.
//  One sub-module: skew_lane_decode (combinational step -> rd_en/rd_elem); FSM, counter and feed regs in top.
// TESTING
//  Memory preloaded mem[r][c] = 16*r+c, DIM=4 throughout.
//  1 start pulse at N, no hold -> feed at N+5 (t=3): lanes {0x30,0x21,0x12,0x03}, feed_valid=4'b1111; done at N+8; busy N+1..N+8.
//  2 Edge steps -> t=0 (N+2): valid=4'b0001, lane0=0x00, others 0; t=6 (N+8): valid=4'b1000, lane3=0x33.
//  3 hold=1 for cycles N+3..N+5 -> feed_* frozen at t=1 values {0x10,0x01}; walk resumes at t=2; done delayed 3 cycles to N+11.
//  4 start re-pulsed at N+4 -> ignored; exactly one done; rd_* unchanged.
//  5 rst=1 at N+4 -> next cycle all outputs 0, IDLE, no done; new start at N+6 runs a full correct walk.
//  6 start held high continuously -> walks back-to-back, done every 9 cycles, one IDLE cycle between tiles.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared constants and state encoding for the systolic-array feed path.
package tpu_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int DIM        = 4;
    localparam int IDXW       = $clog2(DIM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Index of the final diagonal of a dim x dim tile.
    function automatic int last_step(input int dim);
        return 2 * dim - 2;
    endfunction

endpackage

// File: rtl/skew_lane_decode.sv
// Maps the diagonal step to per-column memory read enables and row selects.
module skew_lane_decode #(
    parameter int DIM  = tpu_pkg::DIM,
    parameter int IDXW = tpu_pkg::IDXW
) (
    input  logic                 active,
    input  logic [IDXW:0]        step,
    output logic [DIM-1:0]       rd_en,
    output logic [DIM*IDXW-1:0]  rd_elem
);

    localparam int STEPW = IDXW + 1;
    localparam logic [STEPW-1:0] DIM_W = STEPW'(DIM);

    for (genvar g = 0; g < DIM; g++) begin : g_lane
        localparam logic [STEPW-1:0] LANE = STEPW'(g);
        logic [STEPW-1:0] diff_s;
        logic             en_s;

        // Column g sits on the diagonal once the step reaches it and until DIM rows are consumed.
        assign diff_s = step - LANE;
        assign en_s   = active && (step >= LANE) && (diff_s < DIM_W);

        assign rd_en[g]                  = en_s;
        assign rd_elem[IDXW*g +: IDXW]   = en_s ? diff_s[IDXW-1:0] : {IDXW{1'b0}};
    end

endmodule

// File: rtl/mem_skew_feeder.sv
// Walks one stored tile diagonally and registers the memory read data into skewed feed lanes.
module mem_skew_feeder
    import tpu_pkg::state_e;
    import tpu_pkg::IDLE;
    import tpu_pkg::RUN;
    import tpu_pkg::DRAIN;
    import tpu_pkg::last_step;
#(
    parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH,
    parameter int DIM        = tpu_pkg::DIM
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                hold,
    output logic                                busy,
    output logic                                done,
    output logic [DIM-1:0]                      rd_en,
    output logic [DIM*$clog2(DIM)-1:0]          rd_elem,
    input  logic [DIM*DATA_WIDTH-1:0]           mem_data,
    output logic [DIM*DATA_WIDTH-1:0]           feed_data,
    output logic [DIM-1:0]                      feed_valid
);

    localparam int IDXW  = $clog2(DIM);
    localparam int STEPW = IDXW + 1;
    localparam logic [STEPW-1:0] LAST_STEP = STEPW'(last_step(DIM));

    state_e                     state_r;
    state_e                     state_nxt_s;
    logic [STEPW-1:0]           step_r;
    logic                       busy_r;
    logic [DIM-1:0]             rd_en_s;
    logic [DIM*IDXW-1:0]        rd_elem_s;
    logic [DIM*DATA_WIDTH-1:0]  feed_next_s;
    logic [DIM*DATA_WIDTH-1:0]  feed_data_r;
    logic [DIM-1:0]             feed_valid_r;

    skew_lane_decode #(
        .DIM  (DIM),
        .IDXW (IDXW)
    ) u_decode (
        .active  (state_r == RUN),
        .step    (step_r),
        .rd_en   (rd_en_s),
        .rd_elem (rd_elem_s)
    );

    // Memory read is asynchronous, so disabled columns are zeroed before registering.
    for (genvar g = 0; g < DIM; g++) begin : g_mask
        assign feed_next_s[DATA_WIDTH*g +: DATA_WIDTH] =
            rd_en_s[g] ? mem_data[DATA_WIDTH*g +: DATA_WIDTH] : {DATA_WIDTH{1'b0}};
    end

    // Next-state logic for the tile walk.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_nxt_s = RUN;
                else       state_nxt_s = IDLE;
            end
            RUN: begin
                if (!hold && (step_r == LAST_STEP)) state_nxt_s = DRAIN;
                else                                state_nxt_s = RUN;
            end
            DRAIN: begin
                if (!hold) state_nxt_s = IDLE;
                else       state_nxt_s = DRAIN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register; busy is registered from the next state so it tracks RUN/DRAIN exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    // Diagonal step counter: restarts on acceptance, advances on unstalled RUN cycles, saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_r <= {STEPW{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            step_r <= {STEPW{1'b0}};
        end else if ((state_r == RUN) && !hold && (step_r != LAST_STEP)) begin
            step_r <= step_r + {{(STEPW-1){1'b0}}, 1'b1};
        end
    end

    // Feed lane registers; a hold freezes them, IDLE clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            feed_data_r  <= {(DIM*DATA_WIDTH){1'b0}};
            feed_valid_r <= {DIM{1'b0}};
        end else begin
            case (state_r)
                RUN, DRAIN: begin
                    if (!hold) begin
                        feed_data_r  <= feed_next_s;
                        feed_valid_r <= rd_en_s;
                    end
                end
                default: begin
                    feed_data_r  <= {(DIM*DATA_WIDTH){1'b0}};
                    feed_valid_r <= {DIM{1'b0}};
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = (state_r == DRAIN) && !hold;
    assign rd_en      = rd_en_s;
    assign rd_elem    = rd_elem_s;
    assign feed_data  = feed_data_r;
    assign feed_valid = feed_valid_r;

endmodule

// File: tb/tb_mem_skew_feeder.sv
// Scoreboard bench for mem_skew_feeder against a 4x4 memory holding mem[r][c] = 16*r + c.
module tb_mem_skew_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        hold;
    logic        busy;
    logic        done;
    logic [3:0]  rd_en;
    logic [7:0]  rd_elem;
    logic [31:0] mem_data;
    logic [31:0] feed_data;
    logic [3:0]  feed_valid;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  v;
    } feed_t;

    // Hand-computed wavefront for steps 0..6; lane i occupies bits [8i +: 8].
    localparam logic [31:0] EXP_D [7] = '{32'h00000000, 32'h00000110, 32'h00021120,
                                          32'h03122130, 32'h13223100, 32'h23320000,
                                          32'h33000000};
    localparam logic [3:0]  EXP_V [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                          4'b1110, 4'b1100, 4'b1000};

    feed_t sb_q[$];
    feed_t mon_e;
    feed_t last_s;
    int    done_log[$];
    int    cyc = 0;
    int    pass_cnt = 0;
    int    tot_cnt = 0;
    logic  upd_q = 1'b0;
    logic  frz_q = 1'b0;
    int    n0;
    int    m0;

    mem_skew_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .hold       (hold),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_elem    (rd_elem),
        .mem_data   (mem_data),
        .feed_data  (feed_data),
        .feed_valid (feed_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Asynchronous memory: column c returns row rd_elem[c] regardless of enable.
    always_comb begin
        mem_data = 32'h0;
        for (int c = 0; c < 4; c++) begin
            mem_data[8*c +: 8] = {2'b00, rd_elem[2*c +: 2], 4'(c)};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        else             pass_cnt++;
    endtask

    task automatic push_walk();
        for (int t = 0; t < 7; t++) sb_q.push_back({EXP_D[t], EXP_V[t]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_busy"},  32'(busy), 32'h0);
        chk({nm, "_done"},  32'(done), 32'h0);
        chk({nm, "_rd_en"}, 32'(rd_en), 32'h0);
        chk({nm, "_rd_elem"}, 32'(rd_elem), 32'h0);
        chk({nm, "_feed_data"}, feed_data, 32'h0);
        chk({nm, "_feed_valid"}, 32'(feed_valid), 32'h0);
    endtask

    task automatic chk_done(input string nm, input int n, input int first, input int period);
        chk({nm, "_done_count"}, 32'(done_log.size()), 32'(n));
        for (int k = 0; k < n && k < done_log.size(); k++)
            chk({nm, "_done_cycle"}, 32'(done_log[k]), 32'(first + k * period));
        done_log.delete();
    endtask

    // Monitor: pops the scoreboard on every fresh non-empty feed, checks freezing on held cycles.
    always @(negedge clk) begin
        if (done === 1'b1) done_log.push_back(cyc);
        if (upd_q && (feed_valid !== 4'b0000)) begin
            if (sb_q.size() == 0) begin
                chk("feed_unexpected", 32'(feed_valid), 32'h0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("feed_data", feed_data, mon_e.d);
                chk("feed_valid", 32'(feed_valid), 32'(mon_e.v));
            end
            last_s = {feed_data, feed_valid};
        end else if (frz_q) begin
            chk("hold_feed_data", feed_data, last_s.d);
            chk("hold_feed_valid", 32'(feed_valid), 32'(last_s.v));
        end
        upd_q = (busy === 1'b1) && (hold === 1'b0) && (rst === 1'b0);
        frz_q = (busy === 1'b1) && (hold === 1'b1) && (rst === 1'b0);
    end

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        tick(); tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick(); tick();
        done_log.delete();

        // Plain walk: busy N+1..N+8, done at N+8, rd_* at steps 0 and 3.
        n0 = cyc; start = 1'b1; push_walk();
        tick(); start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            chk("walk_busy", 32'(busy), (k <= 8) ? 32'h1 : 32'h0);
            if (k == 1) begin
                chk("walk_rd_en_s0", 32'(rd_en), 32'h1);
                chk("walk_rd_elem_s0", 32'(rd_elem), 32'h0);
            end
            if (k == 4) begin
                chk("walk_rd_en_s3", 32'(rd_en), 32'hF);
                chk("walk_rd_elem_s3", 32'(rd_elem), 32'h1B);
            end
            tick();
        end
        chk_done("walk", 1, n0 + 8, 0);

        // Hold in RUN for cycles N+3..N+5: freezes at step 1 output, done moves to N+11.
        n0 = cyc; start = 1'b1; push_walk();
        tick(); start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) hold = 1'b1;
            if (k == 6) hold = 1'b0;
            if (k == 4) begin
                chk("hold_rd_en", 32'(rd_en), 32'h7);
                chk("hold_rd_elem", 32'(rd_elem), 32'h06);
            end
            if (k == 11) chk("hold_busy_drain", 32'(busy), 32'h1);
            if (k == 12) chk("hold_busy_idle", 32'(busy), 32'h0);
            tick();
        end
        chk_done("hold_run", 1, n0 + 11, 0);

        // Hold in DRAIN for N+8..N+9: done suppressed until N+10.
        n0 = cyc; start = 1'b1; push_walk();
        tick(); start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 8)  hold = 1'b1;
            if (k == 10) hold = 1'b0;
            if (k == 10) chk("drain_hold_busy", 32'(busy), 32'h1);
            if (k == 11) chk("drain_hold_idle", 32'(busy), 32'h0);
            tick();
        end
        chk_done("hold_drain", 1, n0 + 10, 0);

        // Start re-pulsed at N+4 while busy: ignored.
        n0 = cyc; start = 1'b1; push_walk();
        tick(); start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            if (k == 4) begin
                chk("restart_rd_en_s3", 32'(rd_en), 32'hF);
                chk("restart_rd_elem_s3", 32'(rd_elem), 32'h1B);
                start = 1'b1;
            end
            if (k == 5) begin
                start = 1'b0;
                chk("restart_rd_en_s4", 32'(rd_en), 32'hE);
                chk("restart_rd_elem_s4", 32'(rd_elem), 32'h6C);
            end
            if (k == 9) chk("restart_busy_idle", 32'(busy), 32'h0);
            tick();
        end
        chk_done("restart", 1, n0 + 8, 0);

        // Reset at N+4 aborts the walk; a fresh start at N+6 completes normally.
        n0 = cyc; start = 1'b1; push_walk();
        tick(); start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_outputs("abort");
        chk("abort_sb_left", 32'(sb_q.size()), 32'h4);
        sb_q.delete();
        tick();
        m0 = cyc; start = 1'b1; push_walk();
        tick(); start = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        chk_done("after_abort", 1, m0 + 8, 0);

        // Start held high: back-to-back tiles with one idle cycle, done every 9 cycles.
        n0 = cyc; start = 1'b1; push_walk(); push_walk(); push_walk();
        for (int k = 1; k <= 29; k++) begin
            tick();
            if (k == 9 || k == 18) chk("b2b_idle_gap", 32'(busy), 32'h0);
            if (k == 19) start = 1'b0;
        end
        chk_done("b2b", 3, n0 + 8, 9);

        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
